ir_key_ctrl: RTL
================

// Module: ir_key_ctrl
// PURPOSE
//  Command controller between the NEC IR receiver and the 6-digit FND display path.
//  Validates each received 32-bit frame and suppresses auto-repeat of a held key.
//  Maps remote keys to digit entry, clear and backspace.
//  Maintains the six BCD digits and the entered-digit mask that drive the display decoders.
// PARAMETERS
//  CUSTOM_CODE  8'h00          expected NEC custom (address) byte
//  CHK_CUSTOM   1'b1           1: frame also rejected on custom mismatch; 0: custom ignored
//  HOLD_CYC     32'd5_000_000  repeat-suppress window in clk cycles (100 ms @ 50 MHz)
// PORTS
//  clk          in   1   50 MHz system clock
//  rst_n        in   1   asynchronous active-low reset
//  i_frame_vld  in   1   one-cycle pulse: i_frame holds a newly completed frame
//  i_frame      in   32  {custom[31:24], ~custom[23:16], cmd[15:8], ~cmd[7:0]}
//  o_digits     out  24  six BCD digits, [3:0] = rightmost digit
//  o_dp         out  6   entered-digit mask, bit i = 1 when digit i holds an entered value
//  o_key        out  8   last accepted command byte
//  o_key_vld    out  1   one-cycle pulse: o_key updated
//  o_err        out  1   one-cycle pulse: checksum or custom fail, or unmapped command
//  o_busy       out  1   high in CHECK/APPLY; i_frame_vld is ignored while high
// BEHAVIOUR
//  Reset values: o_digits=0, o_dp=0, o_key=0, o_key_vld=0, o_err=0, o_busy=0.
//    Internal reset values: state=IDLE, cnt=0, hold_cnt=0, last_cmd=8'hFF.
//  FSM states IDLE, CHECK, APPLY (2-bit encoding).
//  IDLE: when i_frame_vld=1, latch i_frame and go to CHECK. Otherwise stay in IDLE.
//  CHECK: frame is valid iff cmd == ~ncmd, AND (when CHK_CUSTOM=1) custom == ~ncustom
//    and custom == CUSTOM_CODE.
//    - Invalid: o_err=1 for one cycle, go to IDLE.
//    - Valid, cmd == last_cmd and hold_cnt != 0: repeat. Reload hold_cnt = HOLD_CYC-1,
//      no output change, go to IDLE.
//    - Valid otherwise: go to APPLY.
//  APPLY: last_cmd <= cmd, hold_cnt <= HOLD_CYC-1, then return to IDLE.
//    - Digit key: o_digits <= {o_digits[19:0], d}; cnt <= min(cnt+1, 6).
//      When cnt is already 6, the oldest digit is dropped.
//    - CLR key: o_digits <= 0, cnt <= 0.
//    - BS key: o_digits <= {4'd0, o_digits[23:4]}; cnt <= max(cnt-1, 0).
//      BS with cnt=0 changes nothing.
//    - Digit/CLR/BS: o_key <= cmd, o_key_vld=1 for one cycle.
//    - Unmapped cmd: o_err=1 for one cycle; digits, cnt, o_key unchanged.
//      last_cmd and hold_cnt are still updated.
//  o_dp = (6'b1 << cnt) - 1, registered together with o_digits.
//  Latency: sampling edge E moves to CHECK; edge E+1 moves to APPLY or IDLE.
//    o_key_vld, o_digits and o_dp update at edge E+2. o_err updates at E+1 or E+2.
//  hold_cnt: decrements by 1 per clk while nonzero and saturates at 0.
//    A reload takes priority over the decrement.
//  i_frame_vld while o_busy=1: dropped; no queueing, no error.
//  A held key reloads the window on every repeat frame, so it stays suppressed.
//    The same key is accepted again once no frame arrives for HOLD_CYC cycles.
//  rst_n low at any time: all registers return to reset values immediately,
//    including mid-CHECK or mid-APPLY; the frame in flight is lost.
// STRUCTURE
//  Package ir_key_pkg:
//    - state encodings.
//    - KEY_0..KEY_9 = 16,0C,18,5E,08,1C,5A,42,52,4A (hex).
//    - KEY_CLR = 8'h47, KEY_BS = 8'h44.
//    - typedef for key class {DIGIT, CLR, BS, NONE}.
//  Sub-module ir_key_lut: combinational cmd[7:0] -> {class, digit[3:0]}, one instance.
//  Top level: FSM, hold counter, digit shift register.
// TESTING (HOLD_CYC=100 in the bench)
//  1. Frames for KEY_1, KEY_2, KEY_3, spaced 200 cycles apart.
//     -> o_digits=24'h000123, o_dp=6'b000111, three o_key_vld pulses,
//        each at E+2 of its frame.
//  2. Frame 32'h00FF16E8 (bad cmd complement).
//     -> o_err pulse at E+1; o_digits and o_key unchanged; no o_key_vld.
//  3. KEY_5, then KEY_5 again 50 cycles later, then KEY_5 again 250 cycles after that.
//     -> second frame suppressed (no output, window reloaded); third frame accepted.
//     -> o_digits ends with ...55.
//  4. Seven digit keys 1..7, then BS, then CLR.
//     -> after seven keys: o_digits=24'h234567, o_dp=6'h3F.
//     -> after BS: 24'h023456, o_dp=6'h1F.
//     -> after CLR: 0, o_dp=0.
//  5. Second i_frame_vld one cycle after the first (CHECK cycle).
//     -> second frame dropped; exactly one o_key_vld.
//  6. rst_n low at E+1 of a valid KEY_9 frame.
//     -> all outputs 0 and no o_key_vld.
//     -> a KEY_9 sent after reset release is accepted immediately.

Source files
------------

// File: rtl/ir_key_pkg.sv
// Shared definitions for the IR key controller: FSM encoding, NEC command
// codes of the remote, key classes and the digit-mask helper.
package ir_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KC_DIGIT = 2'd0,
        KC_CLR   = 2'd1,
        KC_BS    = 2'd2,
        KC_NONE  = 2'd3
    } key_class_t;

    localparam logic [7:0] KEY_0   = 8'h16;
    localparam logic [7:0] KEY_1   = 8'h0C;
    localparam logic [7:0] KEY_2   = 8'h18;
    localparam logic [7:0] KEY_3   = 8'h5E;
    localparam logic [7:0] KEY_4   = 8'h08;
    localparam logic [7:0] KEY_5   = 8'h1C;
    localparam logic [7:0] KEY_6   = 8'h5A;
    localparam logic [7:0] KEY_7   = 8'h42;
    localparam logic [7:0] KEY_8   = 8'h52;
    localparam logic [7:0] KEY_9   = 8'h4A;
    localparam logic [7:0] KEY_CLR = 8'h47;
    localparam logic [7:0] KEY_BS  = 8'h44;

    localparam logic [2:0] NUM_DIGITS = 3'd6;

    // Mask with the low 'cnt' bits set; a 7-bit intermediate keeps cnt=6 exact.
    function automatic logic [5:0] dp_mask(input logic [2:0] cnt);
        logic [6:0] one_hot;
        one_hot = 7'd1 << cnt;
        return 6'(one_hot - 7'd1);
    endfunction

endpackage

// File: rtl/ir_key_lut.sv
// Combinational decode of an NEC command byte into key class and digit value.
module ir_key_lut
    import ir_key_pkg::*;
(
    input  logic [7:0]  cmd,
    output key_class_t  key_class,
    output logic [3:0]  digit
);

    // Map each remote code to its function; anything else is unmapped.
    always_comb begin
        key_class = KC_NONE;
        digit     = 4'd0;
        case (cmd)
            KEY_0:   begin key_class = KC_DIGIT; digit = 4'd0; end
            KEY_1:   begin key_class = KC_DIGIT; digit = 4'd1; end
            KEY_2:   begin key_class = KC_DIGIT; digit = 4'd2; end
            KEY_3:   begin key_class = KC_DIGIT; digit = 4'd3; end
            KEY_4:   begin key_class = KC_DIGIT; digit = 4'd4; end
            KEY_5:   begin key_class = KC_DIGIT; digit = 4'd5; end
            KEY_6:   begin key_class = KC_DIGIT; digit = 4'd6; end
            KEY_7:   begin key_class = KC_DIGIT; digit = 4'd7; end
            KEY_8:   begin key_class = KC_DIGIT; digit = 4'd8; end
            KEY_9:   begin key_class = KC_DIGIT; digit = 4'd9; end
            KEY_CLR: key_class = KC_CLR;
            KEY_BS:  key_class = KC_BS;
            default: key_class = KC_NONE;
        endcase
    end

endmodule

// File: rtl/ir_key_ctrl.sv
// Command controller between the NEC IR receiver and the 6-digit display:
// validates frames, suppresses auto-repeat of a held key and maintains the
// entered BCD digits plus their occupancy mask.
module ir_key_ctrl
    import ir_key_pkg::*;
#(
    parameter logic [7:0]  CUSTOM_CODE = 8'h00,
    parameter bit          CHK_CUSTOM  = 1'b1,
    parameter logic [31:0] HOLD_CYC    = 32'd5_000_000
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_frame_vld,
    input  logic [31:0] i_frame,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic [7:0]  o_key,
    output logic        o_key_vld,
    output logic        o_err,
    output logic        o_busy
);

    state_t      state, state_next;
    logic [31:0] frame_q;
    logic [31:0] hold_cnt;
    logic [7:0]  last_cmd;
    logic [2:0]  cnt, cnt_next;
    logic [23:0] digits_next;

    logic [7:0]  cust, ncust, cmd, ncmd;
    logic        frame_ok, is_repeat;
    logic        err_set, hold_reload, apply_en;
    key_class_t  key_class;
    logic [3:0]  key_digit;

    assign cust  = frame_q[31:24];
    assign ncust = frame_q[23:16];
    assign cmd   = frame_q[15:8];
    assign ncmd  = frame_q[7:0];

    // Command must carry its own complement; custom byte checked only when enabled.
    always_comb begin
        frame_ok = (cmd == ~ncmd);
        if (CHK_CUSTOM)
            frame_ok = frame_ok && (cust == ~ncust) && (cust == CUSTOM_CODE);
    end

    assign is_repeat = (cmd == last_cmd) && (hold_cnt != 32'd0);
    assign o_busy    = (state != ST_IDLE);

    ir_key_lut u_lut (
        .cmd       (cmd),
        .key_class (key_class),
        .digit     (key_digit)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_next  = state;
        err_set     = 1'b0;
        hold_reload = 1'b0;
        apply_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_frame_vld) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (!frame_ok) begin
                    err_set    = 1'b1;
                    state_next = ST_IDLE;
                end else if (is_repeat) begin
                    hold_reload = 1'b1;
                    state_next  = ST_IDLE;
                end else begin
                    state_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                apply_en    = 1'b1;
                hold_reload = 1'b1;
                err_set     = (key_class == KC_NONE);
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the frame only when idle; frames arriving while busy are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              frame_q <= 32'd0;
        else if (state == ST_IDLE && i_frame_vld) frame_q <= i_frame;
    end

    // Repeat-suppress window: reload wins over the saturating decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  hold_cnt <= 32'd0;
        else if (hold_reload)        hold_cnt <= HOLD_CYC - 32'd1;
        else if (hold_cnt != 32'd0)  hold_cnt <= hold_cnt - 32'd1;
    end

    // Digit register and entry count after applying the decoded key.
    always_comb begin
        digits_next = o_digits;
        cnt_next    = cnt;
        if (apply_en) begin
            case (key_class)
                KC_DIGIT: begin
                    digits_next = {o_digits[19:0], key_digit};
                    cnt_next    = (cnt == NUM_DIGITS) ? NUM_DIGITS : cnt + 3'd1;
                end
                KC_CLR: begin
                    digits_next = 24'd0;
                    cnt_next    = 3'd0;
                end
                KC_BS: begin
                    if (cnt != 3'd0) begin
                        digits_next = {4'd0, o_digits[23:4]};
                        cnt_next    = cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered display state, key report and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_digits  <= 24'd0;
            o_dp      <= 6'd0;
            cnt       <= 3'd0;
            o_key     <= 8'd0;
            o_key_vld <= 1'b0;
            o_err     <= 1'b0;
            last_cmd  <= 8'hFF;
        end else begin
            o_digits  <= digits_next;
            cnt       <= cnt_next;
            o_dp      <= dp_mask(cnt_next);
            o_err     <= err_set;
            o_key_vld <= apply_en && (key_class != KC_NONE);
            if (apply_en) begin
                last_cmd <= cmd;
                if (key_class != KC_NONE) o_key <= cmd;
            end
        end
    end

endmodule
